instruction_memory_banked: RTL

INSTRUCTION_MEMORY_BANKED -- requirements
Module: instruction_memory_banked

---
 rtl/imem_pkg.sv | 19 +
 rtl/SB_SPRAM256KA.sv | 34 +++
 rtl/spram_bank.sv | 36 +++
 rtl/instruction_memory_banked.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared SPRAM geometry, boot-state encoding and mask helper for the banked instruction memory
package imem_pkg;

    localparam int SPRAM_DEPTH = 16384;
    localparam int SPRAM_W     = 16;
    localparam int SPRAM_AW    = $clog2(SPRAM_DEPTH);

    typedef enum logic [1:0] {
        BOOT_FETCH = 2'd0,
        BOOT_WRITE = 2'd1,
        RUN        = 2'd2
    } boot_state_e;

    // One byte enable covers two 4-bit MASKWREN lanes of a 16-bit slice.
    function automatic logic [3:0] nibble_mask(input logic [1:0] byte_en);
        return {byte_en[1], byte_en[1], byte_en[0], byte_en[0]};
    endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// rtl/SB_SPRAM256KA.sv - behavioural model of the iCE40UP 16K x 16 single-port RAM primitive
module SB_SPRAM256KA (
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);

    logic [15:0] mem_q [16384];
    logic        active;

    // POWEROFF is active-low on this primitive.
    assign active = CHIPSELECT & POWEROFF & ~STANDBY & ~SLEEP;

    always_ff @(posedge CLOCK) begin
        if (active && WREN) begin
            for (int n = 0; n < 4; n++) begin
                if (MASKWREN[n]) begin
                    mem_q[ADDRESS][4*n +: 4] <= DATAIN[4*n +: 4];
                end
            end
        end
        if (active && !WREN) begin
            DATAOUT <= mem_q[ADDRESS];
        end
    end

endmodule

// File: rtl/spram_bank.sv
// rtl/spram_bank.sv - one 16K-word bank made of DATA_W/16 SPRAM primitives side by side
module spram_bank
    import imem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic [SPRAM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] mask_i,
    input  logic                wren_i,
    input  logic                cs_i,
    output logic [DATA_W-1:0]   data_o
);

    localparam int SLICES = DATA_W / SPRAM_W;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        logic [3:0] maskwren;
        assign maskwren = nibble_mask(mask_i[2*s +: 2]);

        SB_SPRAM256KA u_spram (
            .ADDRESS    (addr_i),
            .DATAIN     (data_i[s*SPRAM_W +: SPRAM_W]),
            .MASKWREN   (maskwren),
            .WREN       (wren_i),
            .CHIPSELECT (cs_i),
            .CLOCK      (clk_i),
            .STANDBY    (1'b0),
            .SLEEP      (1'b0),
            .POWEROFF   (1'b1),
            .DATAOUT    (data_o[s*SPRAM_W +: SPRAM_W])
        );
    end

endmodule

// File: rtl/instruction_memory_banked.sv
// rtl/instruction_memory_banked.sv - pipelined banked SPRAM instruction memory; boot copy enabled by IMEM_BOOT_COPY_EN
module instruction_memory_banked
    import imem_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  BANKS      = 1,
    parameter int  BOOT_WORDS = 1024,
    localparam int ADDR_W     = SPRAM_AW + $clog2(BANKS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_mask,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                ready,
    output logic                addr_err,
    output logic                boot_req,
    output logic [ADDR_W-1:0]   boot_addr,
    input  logic [DATA_W-1:0]   boot_data,
    input  logic                boot_ack
);

    localparam int              BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int              MASK_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] MEM_WORDS = (ADDR_W + 1)'(BANKS * SPRAM_DEPTH);

    logic              run;
    logic              boot_wr;
    logic [ADDR_W-1:0] boot_wr_addr;
    logic [DATA_W-1:0] boot_wr_data;

`ifdef IMEM_BOOT_COPY_EN
    localparam logic [ADDR_W-1:0] LAST_BOOT = ADDR_W'(BOOT_WORDS - 1);

    boot_state_e       state_q, state_d;
    logic              boot_req_q, boot_req_d;
    logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
    logic [DATA_W-1:0] boot_data_q, boot_data_d;

    always_comb begin
        state_d     = state_q;
        boot_req_d  = boot_req_q;
        boot_addr_d = boot_addr_q;
        boot_data_d = boot_data_q;
        case (state_q)
            BOOT_FETCH: begin
                boot_req_d = 1'b1;
                if (boot_req_q && boot_ack) begin
                    boot_data_d = boot_data;
                    boot_req_d  = 1'b0;
                    state_d     = BOOT_WRITE;
                end
            end
            BOOT_WRITE: begin
                if (boot_addr_q == LAST_BOOT) begin
                    state_d = RUN;
                end else begin
                    boot_addr_d = boot_addr_q + 1'b1;
                    boot_req_d  = 1'b1;
                    state_d     = BOOT_FETCH;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BOOT_FETCH;
            boot_req_q  <= 1'b0;
            boot_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_req_q  <= boot_req_d;
            boot_addr_q <= boot_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        boot_data_q <= boot_data_d;
    end

    assign run          = (state_q == RUN);
    assign boot_wr      = (state_q == BOOT_WRITE);
    assign boot_wr_addr = boot_addr_q;
    assign boot_wr_data = boot_data_q;
    assign boot_req     = boot_req_q;
    assign boot_addr    = boot_addr_q;
`else
    logic ready_q;
    logic unused_boot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign run          = ready_q;
    assign boot_wr      = 1'b0;
    assign boot_wr_addr = '0;
    assign boot_wr_data = '0;
    assign boot_req     = 1'b0;
    assign boot_addr    = '0;
    assign unused_boot  = ^{boot_data, boot_ack};
`endif

    // Stage 1: host request registers; write wins over a simultaneous read.
    logic              s1_rd_q, s1_wr_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [MASK_W-1:0] s1_mask_q;
    logic              s1_oob;
    logic [BANK_W-1:0] s1_bank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_rd_q <= 1'b0;
            s1_wr_q <= 1'b0;
        end else begin
            s1_rd_q <= run & rd_en & ~wr_en;
            s1_wr_q <= run & wr_en;
        end
    end

    always_ff @(posedge clk) begin
        s1_addr_q <= addr;
        s1_data_q <= wr_data;
        s1_mask_q <= wr_mask;
    end

    assign s1_oob  = {1'b0, s1_addr_q} >= MEM_WORDS;
    assign s1_bank = BANK_W'(s1_addr_q >> SPRAM_AW);

    logic [SPRAM_AW-1:0] mem_addr;
    logic [BANK_W-1:0]   mem_bank;
    logic [DATA_W-1:0]   mem_data;
    logic [MASK_W-1:0]   mem_mask;
    logic                mem_wr, mem_rd;

    always_comb begin
        if (boot_wr) begin
            mem_addr = boot_wr_addr[SPRAM_AW-1:0];
            mem_bank = BANK_W'(boot_wr_addr >> SPRAM_AW);
            mem_data = boot_wr_data;
            mem_mask = '1;
            mem_wr   = 1'b1;
            mem_rd   = 1'b0;
        end else begin
            mem_addr = s1_addr_q[SPRAM_AW-1:0];
            mem_bank = s1_bank;
            mem_data = s1_data_q;
            mem_mask = s1_mask_q;
            mem_wr   = s1_wr_q & ~s1_oob;
            mem_rd   = s1_rd_q & ~s1_oob;
        end
    end

    logic [DATA_W-1:0] bank_dout [BANKS];

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic sel;
        assign sel = (mem_bank == BANK_W'(b));

        spram_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk_i  (clk),
            .addr_i (mem_addr),
            .data_i (mem_data),
            .mask_i (mem_mask),
            .wren_i (mem_wr & sel),
            .cs_i   ((mem_wr | mem_rd) & sel),
            .data_o (bank_dout[b])
        );
    end

    // Stage 2: bank select and range flag travel alongside the SPRAM read.
    logic              s2_rd_q, s2_err_q, s2_oob_q;
    logic [BANK_W-1:0] s2_bank_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic [DATA_W-1:0] rd_fresh;

    always_comb begin
        rd_fresh = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (!s2_oob_q && s2_bank_q == BANK_W'(b)) begin
                rd_fresh = bank_dout[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_rd_q   <= 1'b0;
            s2_err_q  <= 1'b0;
            rd_hold_q <= '0;
        end else begin
            s2_rd_q  <= s1_rd_q;
            s2_err_q <= (s1_rd_q | s1_wr_q) & s1_oob;
            if (s2_rd_q) begin
                rd_hold_q <= rd_fresh;
            end
        end
    end

    always_ff @(posedge clk) begin
        s2_bank_q <= s1_bank;
        s2_oob_q  <= s1_oob;
    end

    assign rd_data  = s2_rd_q ? rd_fresh : rd_hold_q;
    assign rd_valid = s2_rd_q;
    assign addr_err = s2_err_q;
    assign ready    = run;

endmodule
